// File: rtl/if_fetch_buf_pkg.sv
// if_fetch_buf_pkg: shared constants and the fetch-entry type
// for the instruction-fetch buffer and its prefetch FIFO.
package if_fetch_buf_pkg;

  localparam int unsigned ADDR_W_DEF   = 14;
  localparam int unsigned DEPTH_DEF    = 2;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        misalign;
  } fetch_ent_t;

endpackage

// File: rtl/if_fifo.sv
// if_fifo: synchronous prefetch FIFO with clear, push/pop, count,
// full/empty. Ports: clk_i, rst_ni, clr_i, push_i, pop_i, data_i,
// head_o, count_o, full_o, empty_o. Reset is synchronous active-low.
module if_fifo
  import if_fetch_buf_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  fetch_ent_t    data_i,
  output fetch_ent_t    head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  fetch_ent_t    mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_C);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & ~full_o;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (do_pop)  rd_d = rd_q + PW'(1);
    if (do_push) wr_d = wr_q + PW'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: empty_o masks stale entries.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/if_fetch_buf.sv
// if_fetch_buf: fetch stage between PC and decode. Issues IROM word
// reads (1-cycle latency), buffers {pc, inst} in if_fifo, hands the
// head to decode via valid/ready, back-pressures PC via pc_adv_o,
// and discards buffered/in-flight work on flush_i.
// Ports: clk_if, rst_if_n (sync, active-low), pc_i, pc_adv_o,
// flush_i, irom_req_o, irom_addr_o, irom_rdata_i, inst_valid_o,
// inst_o, inst_pc_o, inst_ready_i.
// Macro IF_MISALIGN_CHK_EN: misaligned pc yields a flagged NOP entry
// instead of an IROM read, and adds output inst_misalign_o.
module if_fetch_buf
  import if_fetch_buf_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic              clk_if,
  input  logic              rst_if_n,
  input  logic [31:0]       pc_i,
  output logic              pc_adv_o,
  input  logic              flush_i,
  output logic              irom_req_o,
  output logic [ADDR_W-1:0] irom_addr_o,
  input  logic [31:0]       irom_rdata_i,
  output logic              inst_valid_o,
  output logic [31:0]       inst_o,
  output logic [31:0]       inst_pc_o,
`ifdef IF_MISALIGN_CHK_EN
  output logic              inst_misalign_o,
`endif
  input  logic              inst_ready_i
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic          inflight_q, inflight_d;
  logic          drop_q, drop_d;
  logic          mis_q, mis_d;
  logic [31:0]   req_pc_q, req_pc_d;

  logic [CW-1:0] count;
  logic [CW:0]   occ;
  logic          full, empty;
  logic          issue, misal;
  logic          push, pop;
  fetch_ent_t    head, push_ent;

  // Occupancy counts in-flight reads so the FIFO can never overflow;
  // a same-cycle pop deliberately does not free room.
  assign occ   = {1'b0, count} + {{CW{1'b0}}, inflight_q};
  assign issue = rst_if_n & ~flush_i & (occ < DEPTH_C);

`ifdef IF_MISALIGN_CHK_EN
  assign misal = (pc_i[1:0] != 2'b00);
`else
  assign misal = 1'b0;
`endif

  assign irom_req_o  = issue & ~misal;
  assign pc_adv_o    = irom_req_o;
  assign irom_addr_o = pc_i[ADDR_W+1:2];

  // A misaligned slot rides the in-flight path so at most one
  // entry enters the FIFO per cycle.
  assign push     = inflight_q & ~drop_q & ~flush_i;
  assign pop      = inst_valid_o & inst_ready_i & ~flush_i;
  assign push_ent = '{pc:       req_pc_q,
                      inst:     mis_q ? NOP_INST : irom_rdata_i,
                      misalign: mis_q};

  always_comb begin
    inflight_d = issue;
    mis_d      = issue & misal;
    req_pc_d   = issue ? pc_i : req_pc_q;
    drop_d     = flush_i & inflight_q;
  end

  always_ff @(posedge clk_if) begin
    if (!rst_if_n) begin
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
      mis_q      <= 1'b0;
      req_pc_q   <= '0;
    end else begin
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      mis_q      <= mis_d;
      req_pc_q   <= req_pc_d;
    end
  end

  if_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_if),
    .rst_ni  (rst_if_n),
    .clr_i   (flush_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (push_ent),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign inst_valid_o = ~empty;
  assign inst_o       = empty ? NOP_INST : head.inst;
  assign inst_pc_o    = empty ? 32'h0 : head.pc;

`ifdef IF_MISALIGN_CHK_EN
  assign inst_misalign_o = ~empty & head.misalign;
`else
  logic unused_mis;
  assign unused_mis = head.misalign;
`endif

  a_no_ovf: assert property (@(posedge clk_if) disable iff (!rst_if_n)
    !(push && full));

endmodule

// File: tb/tb_if_fetch_buf.sv
// tb_if_fetch_buf: queue-based reference model checked every cycle,
// plus directed literal expectations for if_fetch_buf.
module tb_if_fetch_buf;

  localparam int          DP  = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_if_n;
  logic [31:0] pc_i;
  logic        pc_adv_o;
  logic        flush_i;
  logic        irom_req_o;
  logic [13:0] irom_addr_o;
  logic [31:0] irom_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i;
`ifdef IF_MISALIGN_CHK_EN
  logic        inst_misalign_o;
`endif

  always #5 clk = ~clk;

  if_fetch_buf dut (
    .clk_if          (clk),
    .rst_if_n        (rst_if_n),
    .pc_i            (pc_i),
    .pc_adv_o        (pc_adv_o),
    .flush_i         (flush_i),
    .irom_req_o      (irom_req_o),
    .irom_addr_o     (irom_addr_o),
    .irom_rdata_i    (irom_rdata_i),
    .inst_valid_o    (inst_valid_o),
    .inst_o          (inst_o),
    .inst_pc_o       (inst_pc_o),
`ifdef IF_MISALIGN_CHK_EN
    .inst_misalign_o (inst_misalign_o),
`endif
    .inst_ready_i    (inst_ready_i)
  );

  // PC stage and IROM
  logic [31:0] pc_q;
  logic [31:0] tgt;
  assign pc_i = pc_q;

  always @(posedge clk) begin
    if (!rst_if_n)     pc_q <= 32'h0;
    else if (flush_i)  pc_q <= tgt;
    else if (pc_adv_o) pc_q <= pc_q + 32'd4;
  end

  initial irom_rdata_i = 32'h0;
  always @(posedge clk) begin
    if (irom_req_o)
      irom_rdata_i <= 32'h1000_0000 + {18'b0, irom_addr_o};
  end

  // Checking helpers
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk32(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
               $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act,
                      input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp,
               $time);
    end
  endtask

  // Reference model: FIFO contents as a queue plus one pending read
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        mis;
  } ent_t;

  ent_t        mq[$];
  bit          pend;
  bit          pend_mis;
  logic [31:0] pend_pc;
  bit          chk_on = 0;

  always @(negedge clk) begin
    #3;
    if (chk_on) begin
      bit iss, mis, ereq;
      ent_t e;
      iss = rst_if_n && !flush_i && ((mq.size() + int'(pend)) < DP);
      mis = 1'b0;
`ifdef IF_MISALIGN_CHK_EN
      mis = (pc_i[1:0] != 2'b00);
`endif
      ereq = iss && !mis;
      chk1("m_irom_req", irom_req_o, ereq);
      chk1("m_pc_adv", pc_adv_o, ereq);
      if (ereq)
        chk32("m_irom_addr", {18'b0, irom_addr_o},
              {18'b0, pc_i[15:2]});
      chk1("m_valid", inst_valid_o, mq.size() != 0);
      chk32("m_inst", inst_o, mq.size() != 0 ? mq[0].inst : NOP);
      chk32("m_inst_pc", inst_pc_o,
            mq.size() != 0 ? mq[0].pc : 32'h0);
`ifdef IF_MISALIGN_CHK_EN
      chk1("m_misalign", inst_misalign_o,
           mq.size() != 0 ? mq[0].mis : 1'b0);
`endif
      if (!rst_if_n || flush_i) begin
        mq.delete();
        pend = 0;
      end else begin
        if (mq.size() != 0 && inst_ready_i) mq.delete(0);
        if (pend) begin
          e.pc   = pend_pc;
          e.inst = pend_mis ? NOP
                 : 32'h1000_0000 + {18'b0, pend_pc[15:2]};
          e.mis  = pend_mis;
          mq.push_back(e);
        end
        pend     = iss;
        pend_pc  = pc_i;
        pend_mis = mis;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    rst_if_n     = 1'b0;
    flush_i      = 1'b0;
    inst_ready_i = 1'b1;
    tgt          = 32'h0;
    repeat (2) @(posedge clk);
    chk_on = 1;

    @(negedge clk); #4;
    chk1("rst_valid", inst_valid_o, 1'b0);
    chk32("rst_inst", inst_o, NOP);
    chk32("rst_pc", inst_pc_o, 32'h0);
    chk1("rst_req", irom_req_o, 1'b0);
    chk1("rst_adv", pc_adv_o, 1'b0);

    // Streaming from pc 0
    @(negedge clk); rst_if_n = 1'b1; #4;
    chk1("rel_req", irom_req_o, 1'b1);
    chk1("rel_valid0", inst_valid_o, 1'b0);
    @(negedge clk); #4;
    chk1("rel_valid1", inst_valid_o, 1'b0);
    @(negedge clk); #4;
    chk1("first_valid", inst_valid_o, 1'b1);
    chk32("first_pc", inst_pc_o, 32'h0);
    chk32("first_inst", inst_o, 32'h1000_0000);
    @(negedge clk); #4;
    chk32("second_pc", inst_pc_o, 32'h4);
    chk32("second_inst", inst_o, 32'h1000_0001);
    @(negedge clk); #4;
    chk1("bubble", inst_valid_o, 1'b0);
    @(negedge clk); #4;
    chk32("third_pc", inst_pc_o, 32'h8);
    chk32("third_inst", inst_o, 32'h1000_0002);

    // Decode stall for 5 cycles
    @(negedge clk); inst_ready_i = 1'b0; #4;
    @(negedge clk); #4;
    @(negedge clk); #4;
    chk1("stall_adv", pc_adv_o, 1'b0);
    chk32("stall_head", inst_pc_o, 32'hC);
    @(negedge clk); #4;
    @(negedge clk); #4;
    chk1("stall_adv2", pc_adv_o, 1'b0);
    chk32("stall_head2", inst_pc_o, 32'hC);
    @(negedge clk); inst_ready_i = 1'b1; #4;
    @(negedge clk); inst_ready_i = 1'b0; #4;
    chk32("after_stall", inst_pc_o, 32'h10);
    chk32("after_stall_i", inst_o, 32'h1000_0004);

    // Flush with one buffered, one in flight
    @(negedge clk);
    flush_i = 1'b1; inst_ready_i = 1'b1; tgt = 32'h40; #4;
    chk1("fl_req", irom_req_o, 1'b0);
    chk32("fl_head", inst_pc_o, 32'h10);
    @(negedge clk); flush_i = 1'b0; #4;
    chk1("fl_valid", inst_valid_o, 1'b0);
    chk1("fl_reissue", irom_req_o, 1'b1);
    chk32("fl_addr", {18'b0, irom_addr_o}, 32'h10);
    @(negedge clk); #4;
    chk1("fl_drop", inst_valid_o, 1'b0);
    @(negedge clk); #4;
    chk32("fl_first_pc", inst_pc_o, 32'h40);
    chk32("fl_first_i", inst_o, 32'h1000_0010);

    // Mixed ready pattern
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); inst_ready_i = (i % 3) != 0; #4;
    end

    // Reset pulse mid-stream
    @(negedge clk); inst_ready_i = 1'b1; rst_if_n = 1'b0; #4;
    chk1("mr_req", irom_req_o, 1'b0);
    chk1("mr_adv", pc_adv_o, 1'b0);
    @(negedge clk); rst_if_n = 1'b1; #4;
    chk1("mr_valid", inst_valid_o, 1'b0);
    chk32("mr_inst", inst_o, NOP);
    chk32("mr_pc", inst_pc_o, 32'h0);
    chk32("mr_addr", {18'b0, irom_addr_o}, 32'h0);
    @(negedge clk); #4;
    chk1("mr_nocap", inst_valid_o, 1'b0);
    @(negedge clk); #4;
    chk32("mr_first", inst_pc_o, 32'h0);
    chk32("mr_first_i", inst_o, 32'h1000_0000);
    repeat (6) begin
      @(negedge clk); #4;
    end

`ifdef IF_MISALIGN_CHK_EN
    @(negedge clk); flush_i = 1'b1; tgt = 32'h6; #4;
    @(negedge clk); flush_i = 1'b0; inst_ready_i = 1'b0; #4;
    chk1("mis_req", irom_req_o, 1'b0);
    chk1("mis_adv", pc_adv_o, 1'b0);
    @(negedge clk); #4;
    @(negedge clk); #4;
    chk1("mis_valid", inst_valid_o, 1'b1);
    chk32("mis_pc", inst_pc_o, 32'h6);
    chk32("mis_inst", inst_o, NOP);
    chk1("mis_flag", inst_misalign_o, 1'b1);
    chk1("mis_req2", irom_req_o, 1'b0);
`endif

    chk_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
